// File: rtl/mem_responder.sv
// mem_responder: serves MREAD/MWRITE commands from a 256x16 RAM, an LED register and a switch port.
// Define MEM_RESP_ERR_EN to enable the sticky err flag; otherwise err is tied low.
module mem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RAM_DEPTH = 256,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] LED_ADDR = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        sw_in,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              busy,
  output logic [7:0]        led_out,
  output logic              err
);
  localparam logic [1:0] MREAD = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;
  localparam int RA_W = $clog2(RAM_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0] led_q, led_d;
  logic ready_q;
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];
  logic is_ram, is_led, is_sw, rd, wr;
  always_comb begin
    is_ram = {1'b0, addr_q} < (ADDR_W+1)'(RAM_DEPTH);
    is_led = addr_q == LED_ADDR;
    is_sw = addr_q == SW_ADDR;
    rd = state_q == ACCESS && cmd_q == MREAD;
    wr = state_q == ACCESS && cmd_q == MWRITE;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cmd_d = cmd_q;
    addr_d = addr_q;
    data_d = data_q;
    case (state_q)
      IDLE:
        if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
          cmd_d = mem_cmd;
          addr_d = mem_addr;
          data_d = write_data;
          cnt_d = 4'(WAIT_STATES);
          state_d = WAIT_STATES > 0 ? WAIT : ACCESS;
        end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? ACCESS : WAIT;
      end
      ACCESS: state_d = DONE;
      default: state_d = IDLE;
    endcase
    rdata_d = !rd ? rdata_q :
              is_ram ? ram_q[addr_q[RA_W-1:0]] :
              is_sw ? {{(DATA_W-8){1'b0}}, sw_in} :
              is_led ? {{(DATA_W-8){1'b0}}, led_q} : '0;
    led_d = wr && is_led ? data_q[7:0] : led_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cmd_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      rdata_q <= '0;
      led_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      data_q <= data_d;
      rdata_q <= rdata_d;
      led_q <= led_d;
      ready_q <= state_q == DONE;
    end
  // RAM has no reset; writes only happen on a completed ACCESS edge
  always_ff @(posedge clk)
    if (wr && is_ram) ram_q[addr_q[RA_W-1:0]] <= data_q;
`ifdef MEM_RESP_ERR_EN
  logic err_q, err_d, bad;
  always_comb begin
    bad = (rd || wr) && !is_ram && !is_led && !(rd && is_sw);
    err_d = err_q || bad || (state_q == IDLE && mem_cmd == 2'b11);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif
  assign read_data = rdata_q;
  assign mem_ready = ready_q;
  assign busy = state_q != IDLE;
  assign led_out = led_q;
endmodule
